sr_cmd_gen: RTL and testbench
=============================

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 16, consecutive stable cycles required before a debounced level changes (legal range 1..65535).
REQ-002 Parameter GAP_CYCLES, default 4, idle cycles enforced after each issued command (0 permitted).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 set_in  input  1  raw asynchronous set request (button/pin).
REQ-006 clr_in  input  1  raw asynchronous clear request (button/pin).
REQ-007 conflict_clr  input  1  synchronous clear of the conflict flag.
REQ-008 S  output  1  set command to the downstream SR stage, registered.
REQ-009 R  output  1  reset command to the downstream SR stage, registered.
REQ-010 enable  output  1  one-cycle command strobe to the downstream SR stage, registered.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 conflict  output  1  sticky flag: simultaneous set and clear requests were detected.
REQ-013 cmd_count  output  8  number of issued commands, modulo 256.

Function
REQ-014 Each raw input SHALL pass through a 2-flop synchronizer.
REQ-015 Debounce: the stable level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any matching cycle reloads the counter.
REQ-016 A rising edge of a stable level SHALL produce a one-cycle request; falling edges produce nothing.
REQ-017 Each request SHALL set its pending bit (set_pend or clr_pend) and clear the opposite pending bit (newest request wins).
REQ-018 Set and clear requests in the same cycle SHALL clear both pending bits, pend nothing, and set conflict.
REQ-019 conflict SHALL hold until conflict_clr is asserted; if a new conflict and conflict_clr occur in the same cycle, conflict SHALL remain 1.
REQ-020 FSM states: IDLE, ISSUE, LOCKOUT.
REQ-021 IDLE -> ISSUE when any pending bit is set.
REQ-022 ISSUE SHALL last exactly one cycle with enable=1, S=set_pend, and R=clr_pend; the issued pending bit clears and cmd_count increments (255 wraps to 0).
REQ-023 ISSUE -> LOCKOUT, with the gap counter loaded with GAP_CYCLES; if GAP_CYCLES=0, ISSUE -> IDLE directly.
REQ-024 LOCKOUT SHALL decrement the gap counter each cycle and go to IDLE after GAP_CYCLES cycles; requests arriving during ISSUE or LOCKOUT only update the pending bits per REQ-017/018.
REQ-025 Latency from IDLE: with edge k the first to sample the new raw level, enable SHALL be high in the cycle following edge k+DEB_CYCLES+3.
REQ-026 Outside ISSUE, S, R, and enable SHALL all be 0; S and R SHALL never both be 1.

Reset
REQ-027 Reset SHALL force S=0, R=0, enable=0, busy=0, conflict=0, and cmd_count=0; it SHALL also clear the synchronizers, stable levels, debounce counters, pending bits, and gap counter, and set the FSM to IDLE.
REQ-028 Reset mid-ISSUE or mid-LOCKOUT SHALL abort with no strobe in the following cycle.
REQ-029 A raw input held high through reset SHALL produce exactly one command after it re-debounces.

Structure
REQ-030 Package sr_cmd_pkg SHALL hold the FSM state enum and the default DEB_CYCLES and GAP_CYCLES constants.
REQ-031 Sub-module sr_debounce (synchronizer, debounce counter, and rising-edge detect) SHALL be instantiated twice, once per raw input.

Verification (DEB_CYCLES=4, GAP_CYCLES=3)
REQ-032 set_in rises at edge 10 and stays high -> one enable with S=1 and R=0 in the cycle after edge 17; cmd_count=1; busy high for 4 cycles.
REQ-033 set_in glitches high for 3 cycles -> no enable, and cmd_count stays 0.
REQ-034 set_in and clr_in rise at the same edge -> no enable and conflict=1; conflict_clr pulse -> conflict=0.
REQ-035 set_in issued, then clr_in debounced during LOCKOUT -> second strobe with R=1 on the first cycle after LOCKOUT ends; S and R never both 1.
REQ-036 Reset asserted during LOCKOUT with clr_pend set -> no strobe after reset, and all outputs are 0.
REQ-037 256 issued commands -> cmd_count wraps to 0.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types and default timing constants for the SR command generator.
package sr_cmd_pkg;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int GAP_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, debounce counter and rising-edge pulse for one raw pin.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic [15:0] cnt;

  // Synchronize, then accept a new level only after DEB_CYCLES differing samples in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= 16'd0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= 16'd0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= 16'd0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced set/clear requests turned into single, rate-limited S/R command strobes.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_in,
  input  logic       clr_in,
  input  logic       conflict_clr,
  output logic       S,
  output logic       R,
  output logic       enable,
  output logic       busy,
  output logic       conflict,
  output logic [7:0] cmd_count
);

  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

  state_t      state;
  state_t      state_nx;
  logic [15:0] gap;
  logic [15:0] gap_nx;
  logic        issue_go;
  logic        set_rq;
  logic        clr_rq;
  logic        set_pend;
  logic        clr_pend;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk   (clk),
    .reset (reset),
    .raw   (set_in),
    .rise  (set_rq)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .reset (reset),
    .raw   (clr_in),
    .rise  (clr_rq)
  );

  // Next-state and lockout counter; the ISSUE entry is flagged so outputs can be registered.
  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    issue_go = 1'b0;
    case (state)
      ST_IDLE: begin
        if (set_pend || clr_pend) begin
          state_nx = ST_ISSUE;
          issue_go = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (GAP_CYCLES == 0) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_LOCKOUT;
          gap_nx   = GAP_LOAD;
        end
      end
      ST_LOCKOUT: begin
        if (gap <= 16'd1) begin
          state_nx = ST_IDLE;
          gap_nx   = 16'd0;
        end else begin
          gap_nx = gap - 16'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        gap_nx   = 16'd0;
      end
    endcase
  end

  // State, registered command outputs, pending bits and the sticky conflict flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      gap       <= 16'd0;
      S         <= 1'b0;
      R         <= 1'b0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      conflict  <= 1'b0;
      cmd_count <= 8'd0;
      set_pend  <= 1'b0;
      clr_pend  <= 1'b0;
    end else begin
      state  <= state_nx;
      gap    <= gap_nx;
      enable <= issue_go;
      S      <= issue_go & set_pend;
      R      <= issue_go & clr_pend;
      busy   <= (state_nx != ST_IDLE);
      if (issue_go) begin
        cmd_count <= cmd_count + 8'd1;
      end
      // A fresh request outranks clearing the bit that is being issued.
      if (set_rq && clr_rq) begin
        set_pend <= 1'b0;
        clr_pend <= 1'b0;
      end else if (set_rq) begin
        set_pend <= 1'b1;
        clr_pend <= 1'b0;
      end else if (clr_rq) begin
        set_pend <= 1'b0;
        clr_pend <= 1'b1;
      end else if (issue_go) begin
        set_pend <= 1'b0;
        clr_pend <= 1'b0;
      end
      if (set_rq && clr_rq) begin
        conflict <= 1'b1;
      end else if (conflict_clr) begin
        conflict <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench: timeline-based reference model plus directed and random stimulus.
module tb_sr_cmd_gen;

  localparam int DEB  = 4;
  localparam int GAP  = 3;
  localparam int HMAX = 16384;

  logic       clk = 1'b0;
  logic       reset;
  logic       set_in;
  logic       clr_in;
  logic       conflict_clr;
  logic       S;
  logic       R;
  logic       enable;
  logic       busy;
  logic       conflict;
  logic [7:0] cmd_count;

  sr_cmd_gen #(.DEB_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .set_in       (set_in),
    .clr_in       (clr_in),
    .conflict_clr (conflict_clr),
    .S            (S),
    .R            (R),
    .enable       (enable),
    .busy         (busy),
    .conflict     (conflict),
    .cmd_count    (cmd_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: raw sample history per edge, debounced levels, pending bits, issue timeline.
  bit raw_h [0:1][0:HMAX-1];
  int edge_n = 0;
  int m_last_reset = -1;
  int m_last_issue = -1000;
  bit m_lvl [0:1];
  bit m_rise [0:1];
  bit m_pend_s, m_pend_c, m_conf;
  int m_count;
  bit e_s, e_r, e_en, e_busy;

  // Observation bookkeeping for the directed scenarios.
  int tick_idx;
  int en_ticks[$];
  int en_sr[$];
  int busy_cnt;

  function automatic bit sync_at(int ch, int e);
    if (e - 2 <= m_last_reset || e - 2 < 0) return 1'b0;
    return raw_h[ch][e-2];
  endfunction

  task automatic model_step();
    bit rs, rc, issue, idle_prev, all_diff;
    int e;
    e  = edge_n;
    rs = m_rise[0];
    rc = m_rise[1];
    if (reset) begin
      m_last_reset = e;
      m_last_issue = -1000;
      m_lvl[0] = 0; m_lvl[1] = 0; m_rise[0] = 0; m_rise[1] = 0;
      m_pend_s = 0; m_pend_c = 0; m_conf = 0; m_count = 0;
      e_s = 0; e_r = 0; e_en = 0; e_busy = 0;
    end else begin
      if (e < HMAX) begin
        raw_h[0][e] = set_in;
        raw_h[1][e] = clr_in;
      end
      idle_prev = !((m_last_issue <= e - 1) && (e - 1 <= m_last_issue + GAP));
      issue = idle_prev && (m_pend_s || m_pend_c);
      e_en = issue;
      e_s  = issue && m_pend_s;
      e_r  = issue && m_pend_c;
      if (issue) begin
        m_count = (m_count + 1) % 256;
        m_last_issue = e;
      end
      if (rs && rc) begin
        m_pend_s = 0; m_pend_c = 0;
      end else if (rs) begin
        m_pend_s = 1; m_pend_c = 0;
      end else if (rc) begin
        m_pend_s = 0; m_pend_c = 1;
      end else if (issue) begin
        m_pend_s = 0; m_pend_c = 0;
      end
      if (rs && rc) m_conf = 1;
      else if (conflict_clr) m_conf = 0;
      e_busy = (m_last_issue <= e) && (e <= m_last_issue + GAP);
      for (int ch = 0; ch < 2; ch++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) begin
          if (sync_at(ch, e - j) == m_lvl[ch]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_lvl[ch]  = ~m_lvl[ch];
          m_rise[ch] = m_lvl[ch];
        end else begin
          m_rise[ch] = 1'b0;
        end
      end
    end
    edge_n++;
  endtask

  task automatic compare();
    logic [12:0] got, exp;
    got = {S, R, enable, busy, conflict, cmd_count};
    exp = {e_s, e_r, e_en, e_busy, m_conf, 8'(m_count)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL outputs edge=%0d got S R en busy conf cnt=%b %b %b %b %b %0d want %b %b %b %b %b %0d",
               edge_n - 1, got[12], got[11], got[10], got[9], got[8], got[7:0],
               exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    if (enable === 1'b1) begin
      en_ticks.push_back(tick_idx);
      en_sr.push_back(int'({S, R}));
    end
    if (busy === 1'b1) busy_cnt++;
    tick_idx++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mark();
    tick_idx = 0;
    busy_cnt = 0;
    en_ticks.delete();
    en_sr.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
  endtask

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  function automatic int en_at(int k);
    if (en_ticks.size() > k) return en_ticks[k];
    return -1;
  endfunction

  function automatic int sr_at(int k);
    if (en_sr.size() > k) return en_sr[k];
    return -1;
  endfunction

  initial begin
    reset = 1'b1; set_in = 1'b0; clr_in = 1'b0; conflict_clr = 1'b0;
    mark();
    do_reset();
    chk("reset_outputs", int'({S, R, enable, busy, conflict, cmd_count}), 0);

    // Single set command: strobe DEB+3 edges after the first sampling edge, busy GAP+1 cycles.
    mark();
    set_in = 1'b1;
    run(20);
    chk("set_first_enable_tick", en_at(0), 7);
    chk("set_enable_count", en_ticks.size(), 1);
    chk("set_sr", sr_at(0), 2);
    chk("set_cmd_count", int'(cmd_count), 1);
    chk("set_busy_cycles", busy_cnt, 4);

    // Short glitch never debounces.
    set_in = 1'b0;
    do_reset();
    mark();
    set_in = 1'b1;
    run(3);
    set_in = 1'b0;
    run(15);
    chk("glitch_enable_count", en_ticks.size(), 0);
    chk("glitch_cmd_count", int'(cmd_count), 0);

    // Simultaneous requests: conflict, no command; then clear it.
    do_reset();
    mark();
    set_in = 1'b1; clr_in = 1'b1;
    run(15);
    chk("conflict_enable_count", en_ticks.size(), 0);
    chk("conflict_flag", int'(conflict), 1);
    conflict_clr = 1'b1;
    run(1);
    conflict_clr = 1'b0;
    run(1);
    chk("conflict_cleared", int'(conflict), 0);

    // Clear debounced during LOCKOUT issues right after the lockout window.
    set_in = 1'b0; clr_in = 1'b0;
    do_reset();
    mark();
    set_in = 1'b1;
    run(4);
    clr_in = 1'b1;
    run(16);
    chk("lockout_enable_count", en_ticks.size(), 2);
    chk("lockout_first_tick", en_at(0), 7);
    chk("lockout_second_tick", en_at(1), 12);
    chk("lockout_second_sr", sr_at(1), 1);

    // Reset during LOCKOUT with clear pending: nothing issues afterwards.
    set_in = 1'b0; clr_in = 1'b0;
    do_reset();
    mark();
    set_in = 1'b1;
    run(4);
    clr_in = 1'b1;
    run(7);
    set_in = 1'b0; clr_in = 1'b0;
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    chk("abort_outputs_zero", int'({S, R, enable, busy, conflict, cmd_count}), 0);
    mark();
    run(20);
    chk("abort_enable_count", en_ticks.size(), 0);

    // Raw level held through reset yields exactly one command.
    set_in = 1'b1;
    do_reset();
    mark();
    run(30);
    chk("held_enable_count", en_ticks.size(), 1);
    chk("held_cmd_count", int'(cmd_count), 1);

    // 256 commands wrap the counter.
    set_in = 1'b0;
    do_reset();
    mark();
    for (int n = 0; n < 256; n++) begin
      set_in = 1'b1;
      run(8);
      set_in = 1'b0;
      run(8);
    end
    chk("wrap_enable_count", en_ticks.size(), 256);
    chk("wrap_cmd_count", int'(cmd_count), 0);

    // Random pin activity, conflict clears and occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) set_in = ~set_in;
      if ($urandom_range(0, 7) == 0) clr_in = ~clr_in;
      if ($urandom_range(0, 40) == 0) begin
        set_in = 1'b1;
        clr_in = 1'b1;
      end
      conflict_clr = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    conflict_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
